mcpu_ctrl: RTL and testbench
============================

Name: mcpu_ctrl

Overview:
- Moore-style multi-cycle control FSM that sequences the multi-cycle MIPS datapath (IR, MDR, ALUOut and PC registers).
- Decodes the IR contents and drives every datapath select and write-enable.
- Stalls on MIO_ready for every memory access.
- Sits beside the datapath inside the MCPU top level.

Parameters:
STATE_W, 4, width of state register and debug state output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
MIO_ready  in  1  memory/IO transfer complete this cycle
Inst  in  32  IR output (opcode Inst[31:26], funct Inst[5:0])
zero  in  1  ALU zero flag (unused by FSM; branch resolved in datapath)
overflow  in  1  ALU overflow (ignored, no exception support)
IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, shift, unsign  out  1  datapath controls
RegDst, MemtoReg, ALUSrcB, PCSource  out  2  datapath selects
ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 101 SRL, 011 XOR
MemRead, MemWrite, CPU_MIO  out  1  bus strobes; CPU_MIO = MemRead|MemWrite
state  out  STATE_W  current state code (debug)
inst_done  out  1  high in final state of each instruction
illegal  out  1  high in ID when opcode/funct unsupported

Behaviour:
- Output rule: outputs are combinational from state and Inst. Any output not listed for a state is 0.
- Reset: async, state=IF (0). Outputs are therefore IF values; PCWrite is harmless because the PC is held in reset.
- Datapath mux codes:
  - ALUSrcA: 0 PC, 1 rs.
  - ALUSrcB: 0 rt, 1 const 4, 2 Imm, 3 Imm<<2.
  - PCSource: 0 ALU_result, 1 ALUOut, 2 jump target, 3 rs.
  - MemtoReg: 0 ALUOut, 1 MDR, 2 lui, 3 PC.
  - RegDst: 0 rt, 1 rd, 2 $31.
- Supported instructions:
  - R-type funct: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, srl 000010, jr 001000.
  - Opcodes: j 000010, jal 000011, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011.
- States and outputs:
  - IF(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite, IRWrite=MIO_ready. Stays in IF while !MIO_ready; the datapath gates PC CE with MIO_ready, so the PC advances exactly once.
  - ID(1): ALUSrcA=0, ALUSrcB=3, ADD (ALUOut <= PC+4+offset). Next state by decode. Illegal -> IF with illegal=1 and inst_done=1.
  - MA(2), lw/sw address: ALUSrcA=1, ALUSrcB=2, ADD, unsign=0. lw -> MR, sw -> MW.
  - MR(3): MemRead, IorD=1, MA's ALU controls held so ALUOut stays stable. Loops until MIO_ready, then LWB.
  - LWB(4): RegDst=0, MemtoReg=1, RegWrite, inst_done.
  - MW(5): MemWrite, IorD=1, MA's ALU controls held. Loops until MIO_ready, then IF with inst_done on the exit cycle.
  - RX(6): ALUSrcA=1, ALUSrcB=0, op from funct. srl additionally sets shift=1. -> RWB.
  - RWB(7): RegDst=1, MemtoReg=0, RegWrite, inst_done.
  - IX(8): ALUSrcA=1, ALUSrcB=2, op from opcode (addi ADD, slti SLT, andi AND, ori OR, xori XOR). unsign=1 for andi/ori/xori only. -> IWB.
  - IWB(9): RegDst=0, MemtoReg=0, RegWrite, inst_done.
  - BR(10): ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1, PCWriteCond, Branch=1 for beq / 0 for bne, inst_done.
  - JP(11): PCSource=2, PCWrite, inst_done.
  - JAL(12): PCSource=2, PCWrite, RegDst=2, MemtoReg=3, RegWrite, inst_done. The register file samples the old PC (PC+4) on the same edge the PC updates.
  - JR(13): PCSource=3, PCWrite, inst_done.
  - LUI(14): RegDst=0, MemtoReg=2, RegWrite, inst_done.
  - BR, JP, JAL, JR, LUI, LWB, RWB, IWB all -> IF.
- Latency excluding memory waits: lw 5, sw/R/I 4, beq/bne/j/jal/jr/lui 3 cycles.
- Unused state code 15 -> IF, outputs 0.
- Reset asserted mid-instruction aborts immediately to IF; no partial write is issued after reset asserts.
- overflow is ignored; add/addi results are written regardless.

Test Plan:
- Reset, then MIO_ready=1, Inst=add $3,$1,$2 (0x00221820) -> states 0,1,6,7,0; RWB has RegWrite=1, RegDst=1; ALU_operation=010 in RX; inst_done once.
- lw $4,8($1) (0x8C240008), MIO_ready low 2 cycles in MR -> 0,1,2,3,3,3,4,0; IorD=1 and ALUSrcB=2 throughout MR; MemtoReg=1 in LWB.
- beq (0x10220003) then bne (0x14220003) -> BR state with PCWriteCond=1, PCSource=1, SUB; Branch=1 then Branch=0.
- jal 0x0C000010 -> 0,1,12,0; RegDst=2, MemtoReg=3, PCSource=2, RegWrite=1, PCWrite=1 in the same cycle.
- ori (0x34220F0F) -> unsign=1, ALU_operation=001, ALUSrcB=2. srl (0x00021882) -> shift=1, ALU_operation=101.
- Opcode 0x3F in ID -> illegal=1 for one cycle, next state IF. Reset pulsed while in MW -> state=0 asynchronously and MemWrite drops the same cycle.

Source files
------------

// File: rtl/mcpu_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the datapath (slave).
// The controller drives every select and strobe; the datapath returns IR contents and memory status.
interface mcpu_ctrl_if #(
   parameter int STATE_W = 4
);
   logic               MIO_ready;
   logic [31:0]        Inst;
   logic               zero;
   logic               overflow;

   logic               IorD;
   logic               IRWrite;
   logic               RegWrite;
   logic               ALUSrcA;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               Branch;
   logic               shift;
   logic               unsign;
   logic [1:0]         RegDst;
   logic [1:0]         MemtoReg;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSource;
   logic [2:0]         ALU_operation;
   logic               MemRead;
   logic               MemWrite;
   logic               CPU_MIO;
   logic [STATE_W-1:0] state;
   logic               inst_done;
   logic               illegal;

   modport master (
      input  MIO_ready, Inst, zero, overflow,
      output IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, shift, unsign,
             RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation,
             MemRead, MemWrite, CPU_MIO, state, inst_done, illegal
   );

   modport slave (
      output MIO_ready, Inst, zero, overflow,
      input  IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, shift, unsign,
             RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation,
             MemRead, MemWrite, CPU_MIO, state, inst_done, illegal
   );
endinterface

// File: rtl/mcpu_ctrl.sv
// Moore multi-cycle MIPS controller: the state register plus a decode of (state, IR) into
// every datapath select and strobe. Memory states hold until MIO_ready.
module mcpu_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   mcpu_ctrl_if.master bus
);
   typedef enum logic [STATE_W-1:0] {
      S_IF  = STATE_W'(0),
      S_ID  = STATE_W'(1),
      S_MA  = STATE_W'(2),
      S_MR  = STATE_W'(3),
      S_LWB = STATE_W'(4),
      S_MW  = STATE_W'(5),
      S_RX  = STATE_W'(6),
      S_RWB = STATE_W'(7),
      S_IX  = STATE_W'(8),
      S_IWB = STATE_W'(9),
      S_BR  = STATE_W'(10),
      S_JP  = STATE_W'(11),
      S_JAL = STATE_W'(12),
      S_JR  = STATE_W'(13),
      S_LUI = STATE_W'(14)
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   state_t     state_q, state_d;
   logic [5:0] opcode, funct;
   logic [2:0] r_op, i_op;
   logic       r_legal, r_shift, i_unsign;
   logic       unused_inputs;

   assign opcode = bus.Inst[31:26];
   assign funct  = bus.Inst[5:0];

   // Branch outcome is resolved in the datapath, and overflow raises no exception.
   assign unused_inputs = ^{bus.zero, bus.overflow, bus.Inst[25:6]};

   always_comb begin
      r_op    = ALU_ADD;
      r_legal = 1'b1;
      r_shift = 1'b0;
      case (funct)
         6'b100000: r_op = ALU_ADD;
         6'b100010: r_op = ALU_SUB;
         6'b100100: r_op = ALU_AND;
         6'b100101: r_op = ALU_OR;
         6'b100110: r_op = ALU_XOR;
         6'b100111: r_op = ALU_NOR;
         6'b101010: r_op = ALU_SLT;
         6'b000010: begin
            r_op    = ALU_SRL;
            r_shift = 1'b1;
         end
         FN_JR:     r_op = ALU_ADD;
         default:   r_legal = 1'b0;
      endcase
   end

   always_comb begin
      i_op     = ALU_ADD;
      i_unsign = 1'b0;
      case (opcode)
         OP_SLTI: i_op = ALU_SLT;
         OP_ANDI: begin i_op = ALU_AND; i_unsign = 1'b1; end
         OP_ORI:  begin i_op = ALU_OR;  i_unsign = 1'b1; end
         OP_XORI: begin i_op = ALU_XOR; i_unsign = 1'b1; end
         default: i_op = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d           = state_q;
      bus.IorD          = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.ALUSrcA       = 1'b0;
      bus.PCWrite       = 1'b0;
      bus.PCWriteCond   = 1'b0;
      bus.Branch        = 1'b0;
      bus.shift         = 1'b0;
      bus.unsign        = 1'b0;
      bus.RegDst        = 2'd0;
      bus.MemtoReg      = 2'd0;
      bus.ALUSrcB       = 2'd0;
      bus.PCSource      = 2'd0;
      bus.ALU_operation = ALU_AND;
      bus.MemRead       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.inst_done     = 1'b0;
      bus.illegal       = 1'b0;

      case (state_q)
         S_IF: begin
            bus.MemRead       = 1'b1;
            bus.ALUSrcB       = 2'd1;
            bus.ALU_operation = ALU_ADD;
            bus.PCWrite       = 1'b1;
            bus.IRWrite       = bus.MIO_ready;
            if (bus.MIO_ready) state_d = S_ID;
         end
         S_ID: begin
            // ALUOut captures the branch target speculatively while the IR is decoded.
            bus.ALUSrcB       = 2'd3;
            bus.ALU_operation = ALU_ADD;
            case (opcode)
               OP_R: begin
                  if (!r_legal) begin
                     bus.illegal   = 1'b1;
                     bus.inst_done = 1'b1;
                     state_d       = S_IF;
                  end else if (funct == FN_JR) begin
                     state_d = S_JR;
                  end else begin
                     state_d = S_RX;
                  end
               end
               OP_LW, OP_SW:                               state_d = S_MA;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IX;
               OP_BEQ, OP_BNE:                             state_d = S_BR;
               OP_J:                                       state_d = S_JP;
               OP_JAL:                                     state_d = S_JAL;
               OP_LUI:                                     state_d = S_LUI;
               default: begin
                  bus.illegal   = 1'b1;
                  bus.inst_done = 1'b1;
                  state_d       = S_IF;
               end
            endcase
         end
         S_MA: begin
            bus.ALUSrcA       = 1'b1;
            bus.ALUSrcB       = 2'd2;
            bus.ALU_operation = ALU_ADD;
            state_d           = (opcode == OP_SW) ? S_MW : S_MR;
         end
         S_MR: begin
            bus.MemRead       = 1'b1;
            bus.IorD          = 1'b1;
            bus.ALUSrcA       = 1'b1;
            bus.ALUSrcB       = 2'd2;
            bus.ALU_operation = ALU_ADD;
            if (bus.MIO_ready) state_d = S_LWB;
         end
         S_LWB: begin
            bus.MemtoReg  = 2'd1;
            bus.RegWrite  = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         S_MW: begin
            bus.MemWrite      = 1'b1;
            bus.IorD          = 1'b1;
            bus.ALUSrcA       = 1'b1;
            bus.ALUSrcB       = 2'd2;
            bus.ALU_operation = ALU_ADD;
            bus.inst_done     = bus.MIO_ready;
            if (bus.MIO_ready) state_d = S_IF;
         end
         S_RX: begin
            bus.ALUSrcA       = 1'b1;
            bus.ALU_operation = r_op;
            bus.shift         = r_shift;
            state_d           = S_RWB;
         end
         S_RWB: begin
            bus.RegDst    = 2'd1;
            bus.RegWrite  = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         S_IX: begin
            bus.ALUSrcA       = 1'b1;
            bus.ALUSrcB       = 2'd2;
            bus.ALU_operation = i_op;
            bus.unsign        = i_unsign;
            state_d           = S_IWB;
         end
         S_IWB: begin
            bus.RegWrite  = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         S_BR: begin
            bus.ALUSrcA       = 1'b1;
            bus.ALU_operation = ALU_SUB;
            bus.PCSource      = 2'd1;
            bus.PCWriteCond   = 1'b1;
            bus.Branch        = (opcode == OP_BEQ);
            bus.inst_done     = 1'b1;
            state_d           = S_IF;
         end
         S_JP: begin
            bus.PCSource  = 2'd2;
            bus.PCWrite   = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         S_JAL: begin
            // Link value is the pre-jump PC (already PC+4), sampled on the same edge.
            bus.PCSource  = 2'd2;
            bus.PCWrite   = 1'b1;
            bus.RegDst    = 2'd2;
            bus.MemtoReg  = 2'd3;
            bus.RegWrite  = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         S_JR: begin
            bus.PCSource  = 2'd3;
            bus.PCWrite   = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         S_LUI: begin
            bus.MemtoReg  = 2'd2;
            bus.RegWrite  = 1'b1;
            bus.inst_done = 1'b1;
            state_d       = S_IF;
         end
         default: state_d = S_IF;
      endcase

      bus.CPU_MIO = bus.MemRead | bus.MemWrite;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   assign bus.state = state_q;
endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: walks each instruction class through its state sequence
// and compares state codes and control outputs against hand-computed values.
module tb_mcpu_ctrl;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   mcpu_ctrl_if #(.STATE_W(4)) bus ();

   mcpu_ctrl #(.STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic [31:0] inst);
      bus.MIO_ready = rdy;
      bus.Inst      = inst;
      #1;
   endtask

   // Advance one clock and confirm the state code reached.
   task automatic step(input string tag, input logic [3:0] exp_state);
      tick();
      check_eq(tag, 32'(bus.state), 32'(exp_state));
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      reset         = 1'b1;
      bus.MIO_ready = 1'b0;
      bus.Inst      = 32'h0;
      bus.zero      = 1'b0;
      bus.overflow  = 1'b0;

      // Reset: IF outputs, IR write gated by MIO_ready.
      tick();
      check_eq("rst_state",   32'(bus.state),   32'd0);
      check_eq("rst_memread", 32'(bus.MemRead), 32'd1);
      check_eq("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
      check_eq("rst_pcwrite", 32'(bus.PCWrite), 32'd1);
      check_eq("rst_irwrite", 32'(bus.IRWrite), 32'd0);
      check_eq("rst_cpumio",  32'(bus.CPU_MIO), 32'd1);
      $display("txn reset done");

      // add $3,$1,$2 : 0,1,6,7,0
      reset = 1'b0;
      drive(1'b1, 32'h00221820);
      check_eq("add_if_irwrite", 32'(bus.IRWrite), 32'd1);
      check_eq("add_if_done",    32'(bus.inst_done), 32'd0);
      step("add_id", 4'd1);
      check_eq("add_id_done", 32'(bus.inst_done), 32'd0);
      step("add_rx", 4'd6);
      check_eq("add_rx_aluop", 32'(bus.ALU_operation), 32'b010);
      check_eq("add_rx_srca",  32'(bus.ALUSrcA), 32'd1);
      check_eq("add_rx_srcb",  32'(bus.ALUSrcB), 32'd0);
      check_eq("add_rx_done",  32'(bus.inst_done), 32'd0);
      step("add_rwb", 4'd7);
      check_eq("add_rwb_regwrite", 32'(bus.RegWrite), 32'd1);
      check_eq("add_rwb_regdst",   32'(bus.RegDst), 32'd1);
      check_eq("add_rwb_done",     32'(bus.inst_done), 32'd1);
      step("add_back_if", 4'd0);
      check_eq("add_if2_done", 32'(bus.inst_done), 32'd0);
      $display("txn add inst=%08h", bus.Inst);

      // lw $4,8($1) with two wait cycles in MR: 0,1,2,3,3,3,4,0
      drive(1'b1, 32'h8C240008);
      step("lw_id", 4'd1);
      step("lw_ma", 4'd2);
      check_eq("lw_ma_srca", 32'(bus.ALUSrcA), 32'd1);
      check_eq("lw_ma_srcb", 32'(bus.ALUSrcB), 32'd2);
      check_eq("lw_ma_unsign", 32'(bus.unsign), 32'd0);
      drive(1'b0, 32'h8C240008);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("lw_mr%0d", i), 4'd3);
         if (i == 2) drive(1'b1, 32'h8C240008);
         check_eq($sformatf("lw_mr%0d_iord", i), 32'(bus.IorD), 32'd1);
         check_eq($sformatf("lw_mr%0d_srcb", i), 32'(bus.ALUSrcB), 32'd2);
         check_eq($sformatf("lw_mr%0d_rd", i),   32'(bus.MemRead), 32'd1);
         check_eq($sformatf("lw_mr%0d_done", i), 32'(bus.inst_done), 32'd0);
      end
      step("lw_lwb", 4'd4);
      check_eq("lw_lwb_memtoreg", 32'(bus.MemtoReg), 32'd1);
      check_eq("lw_lwb_regdst",   32'(bus.RegDst), 32'd0);
      check_eq("lw_lwb_regwrite", 32'(bus.RegWrite), 32'd1);
      check_eq("lw_lwb_done",     32'(bus.inst_done), 32'd1);
      step("lw_back_if", 4'd0);
      $display("txn lw inst=%08h", bus.Inst);

      // beq then bne
      drive(1'b1, 32'h10220003);
      step("beq_id", 4'd1);
      step("beq_br", 4'd10);
      check_eq("beq_pcwc",   32'(bus.PCWriteCond), 32'd1);
      check_eq("beq_pcsrc",  32'(bus.PCSource), 32'd1);
      check_eq("beq_aluop",  32'(bus.ALU_operation), 32'b110);
      check_eq("beq_branch", 32'(bus.Branch), 32'd1);
      check_eq("beq_done",   32'(bus.inst_done), 32'd1);
      check_eq("beq_pcw",    32'(bus.PCWrite), 32'd0);
      step("beq_back_if", 4'd0);
      $display("txn beq inst=%08h", bus.Inst);
      drive(1'b1, 32'h14220003);
      step("bne_id", 4'd1);
      step("bne_br", 4'd10);
      check_eq("bne_branch", 32'(bus.Branch), 32'd0);
      check_eq("bne_pcwc",   32'(bus.PCWriteCond), 32'd1);
      step("bne_back_if", 4'd0);
      $display("txn bne inst=%08h", bus.Inst);

      // jal: 0,1,12,0
      drive(1'b1, 32'h0C000010);
      step("jal_id", 4'd1);
      step("jal_st", 4'd12);
      check_eq("jal_regdst",   32'(bus.RegDst), 32'd2);
      check_eq("jal_memtoreg", 32'(bus.MemtoReg), 32'd3);
      check_eq("jal_pcsrc",    32'(bus.PCSource), 32'd2);
      check_eq("jal_regwrite", 32'(bus.RegWrite), 32'd1);
      check_eq("jal_pcwrite",  32'(bus.PCWrite), 32'd1);
      step("jal_back_if", 4'd0);
      $display("txn jal inst=%08h", bus.Inst);

      // ori $2,$1,0x0F0F
      drive(1'b1, 32'h34220F0F);
      step("ori_id", 4'd1);
      step("ori_ix", 4'd8);
      check_eq("ori_unsign", 32'(bus.unsign), 32'd1);
      check_eq("ori_aluop",  32'(bus.ALU_operation), 32'b001);
      check_eq("ori_srcb",   32'(bus.ALUSrcB), 32'd2);
      step("ori_iwb", 4'd9);
      check_eq("ori_iwb_regwrite", 32'(bus.RegWrite), 32'd1);
      check_eq("ori_iwb_regdst",   32'(bus.RegDst), 32'd0);
      step("ori_back_if", 4'd0);
      $display("txn ori inst=%08h", bus.Inst);

      // srl $3,$2,2
      drive(1'b1, 32'h00021882);
      step("srl_id", 4'd1);
      step("srl_rx", 4'd6);
      check_eq("srl_shift", 32'(bus.shift), 32'd1);
      check_eq("srl_aluop", 32'(bus.ALU_operation), 32'b101);
      step("srl_rwb", 4'd7);
      step("srl_back_if", 4'd0);
      $display("txn srl inst=%08h", bus.Inst);

      // jr $31, j, lui
      drive(1'b1, 32'h03E00008);
      step("jr_id", 4'd1);
      step("jr_st", 4'd13);
      check_eq("jr_pcsrc", 32'(bus.PCSource), 32'd3);
      step("jr_back_if", 4'd0);
      $display("txn jr inst=%08h", bus.Inst);
      drive(1'b1, 32'h08000010);
      step("j_id", 4'd1);
      step("j_st", 4'd11);
      check_eq("j_pcsrc", 32'(bus.PCSource), 32'd2);
      check_eq("j_regwrite", 32'(bus.RegWrite), 32'd0);
      step("j_back_if", 4'd0);
      $display("txn j inst=%08h", bus.Inst);
      drive(1'b1, 32'h3C011234);
      step("lui_id", 4'd1);
      step("lui_st", 4'd14);
      check_eq("lui_memtoreg", 32'(bus.MemtoReg), 32'd2);
      check_eq("lui_regwrite", 32'(bus.RegWrite), 32'd1);
      step("lui_back_if", 4'd0);
      $display("txn lui inst=%08h", bus.Inst);

      // Illegal opcode 0x3F
      drive(1'b1, 32'hFC000000);
      check_eq("ill_if_flag", 32'(bus.illegal), 32'd0);
      step("ill_id", 4'd1);
      check_eq("ill_flag", 32'(bus.illegal), 32'd1);
      check_eq("ill_done", 32'(bus.inst_done), 32'd1);
      step("ill_back_if", 4'd0);
      check_eq("ill_flag_clear", 32'(bus.illegal), 32'd0);
      $display("txn illegal inst=%08h", bus.Inst);

      // Unsupported R funct is illegal too
      drive(1'b1, 32'h00221821);
      step("illr_id", 4'd1);
      check_eq("illr_flag", 32'(bus.illegal), 32'd1);
      step("illr_back_if", 4'd0);
      $display("txn illegal_r inst=%08h", bus.Inst);

      // sw with ready: exit cycle of MW carries inst_done
      drive(1'b1, 32'hAC240008);
      step("sw_id", 4'd1);
      step("sw_ma", 4'd2);
      step("sw_mw", 4'd5);
      check_eq("sw_mw_memwrite", 32'(bus.MemWrite), 32'd1);
      check_eq("sw_mw_iord",     32'(bus.IorD), 32'd1);
      check_eq("sw_mw_done",     32'(bus.inst_done), 32'd1);
      check_eq("sw_mw_memread",  32'(bus.MemRead), 32'd0);
      step("sw_back_if", 4'd0);
      $display("txn sw inst=%08h", bus.Inst);

      // sw stalled in MW, then reset pulsed mid-cycle
      drive(1'b1, 32'hAC240008);
      step("swr_id", 4'd1);
      step("swr_ma", 4'd2);
      drive(1'b0, 32'hAC240008);
      step("swr_mw", 4'd5);
      check_eq("swr_mw_done",    32'(bus.inst_done), 32'd0);
      check_eq("swr_mw_cpumio",  32'(bus.CPU_MIO), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("swr_rst_state",    32'(bus.state), 32'd0);
      check_eq("swr_rst_memwrite", 32'(bus.MemWrite), 32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 32'h0);
      check_eq("swr_after_state", 32'(bus.state), 32'd0);
      step("if_stall", 4'd0);
      check_eq("if_stall_irwrite", 32'(bus.IRWrite), 32'd0);
      $display("txn sw_reset inst=%08h", 32'hAC240008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
